ysyx_22050710_mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter downstream of the NPC core. Merges the core's IFU instruction-fetch port (read-only) and LSU data port (read/write) onto one memory port, so the core can run against a single multi-cycle memory/bus bridge. The block holds one transaction in flight, with a registered request/grant/response handshake and a per-phase timeout watchdog.

---
 rtl/ysyx_22050710_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ysyx_22050710_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_22050710_mem_arbiter: IFU/LSU to single memory port, one txn in flight |
// | Optional: YSYX_22050710_ARB_RR_EN selects round-robin arbitration.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ysyx_22050710_mem_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ifu_req,
  input  logic [ADDR_WIDTH-1:0]   i_ifu_addr,
  output logic                    o_ifu_gnt,
  output logic                    o_ifu_rvalid,
  output logic [DATA_WIDTH-1:0]   o_ifu_rdata,
  output logic                    o_ifu_err,
  input  logic                    i_lsu_req,
  input  logic                    i_lsu_we,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_addr,
  input  logic [DATA_WIDTH-1:0]   i_lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_lsu_wmask,
  output logic                    o_lsu_gnt,
  output logic                    o_lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   o_lsu_rdata,
  output logic                    o_lsu_err,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wmask,
  input  logic                    i_mem_ready,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam logic [1:0]  c_IDLE     = 2'd0;
  localparam logic [1:0]  c_REQ      = 2'd1;
  localparam logic [1:0]  c_RESP     = 2'd2;
  localparam logic [1:0]  c_OWN_NONE = 2'd0;
  localparam logic [1:0]  c_OWN_IFU  = 2'd1;
  localparam logic [1:0]  c_OWN_LSU  = 2'd2;
  localparam logic        c_TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] c_TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [1:0]              r_owner;
  logic [31:0]             r_tmo_cnt;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [DATA_WIDTH/8-1:0] r_mem_wmask;
  logic                    w_any_req;
  logic                    w_lsu_prio;
  logic                    w_pick_lsu;
  logic                    w_done;
  logic                    w_tmo;
  logic                    w_gnt;
  logic                    w_rvalid;
  logic                    w_fwd_rdata;

`ifdef YSYX_22050710_ARB_RR_EN
  // Remembers which master finished last; reset value makes LSU win the first tie.
  logic r_last_lsu;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_lsu <= 1'b0;
    end else if (w_done) begin
      r_last_lsu <= (r_owner == c_OWN_LSU);
    end
  end
  assign w_lsu_prio = ~r_last_lsu;
`else
  assign w_lsu_prio = 1'b1;
`endif

  assign w_any_req  = i_ifu_req | i_lsu_req;
  assign w_pick_lsu = i_lsu_req & (~i_ifu_req | w_lsu_prio);
  assign w_done     = (r_state != c_IDLE) && (w_state_nxt == c_IDLE);

  // Abort only fires when the current phase made no progress this cycle.
  assign w_tmo = c_TMO_EN && (r_tmo_cnt == c_TMO_LAST) &&
                 (((r_state == c_REQ) && !i_mem_ready) ||
                  ((r_state == c_RESP) && !i_mem_rvalid));

  // State register, owner and per-phase watchdog counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= c_IDLE;
      r_owner   <= c_OWN_NONE;
      r_tmo_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_IDLE && w_any_req) begin
        r_owner <= w_pick_lsu ? c_OWN_LSU : c_OWN_IFU;
      end else if (w_done) begin
        r_owner <= c_OWN_NONE;
      end
      if (w_state_nxt != r_state) begin
        r_tmo_cnt <= 32'd0;
      end else if (r_state != c_IDLE) begin
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (w_any_req) w_state_nxt = c_REQ;
      c_REQ: begin
        if (w_tmo) w_state_nxt = c_IDLE;
        else if (i_mem_ready) w_state_nxt = c_RESP;
      end
      c_RESP: if (i_mem_rvalid || w_tmo) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Memory-side request registers: payload captured once, in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
    end else if (r_state == c_IDLE && w_any_req) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= w_pick_lsu & i_lsu_we;
      r_mem_addr  <= w_pick_lsu ? i_lsu_addr : i_ifu_addr;
      r_mem_wdata <= w_pick_lsu ? i_lsu_wdata : '0;
      r_mem_wmask <= (w_pick_lsu && i_lsu_we) ? i_lsu_wmask : '0;
    end else if (r_state == c_REQ && (i_mem_ready || w_tmo)) begin
      r_mem_req <= 1'b0;
    end
  end

  // Output logic: master-side strobes steered to the owner only.
  always_comb begin
    w_gnt       = (r_state == c_REQ) && (i_mem_ready || w_tmo);
    w_rvalid    = ((r_state == c_REQ) && w_tmo) ||
                  ((r_state == c_RESP) && (i_mem_rvalid || w_tmo));
    w_fwd_rdata = (r_state == c_RESP) && i_mem_rvalid && !r_mem_we;

    o_ifu_gnt    = w_gnt    && (r_owner == c_OWN_IFU);
    o_ifu_rvalid = w_rvalid && (r_owner == c_OWN_IFU);
    o_ifu_err    = w_tmo    && (r_owner == c_OWN_IFU);
    o_ifu_rdata  = (w_fwd_rdata && r_owner == c_OWN_IFU) ? i_mem_rdata : '0;
    o_lsu_gnt    = w_gnt    && (r_owner == c_OWN_LSU);
    o_lsu_rvalid = w_rvalid && (r_owner == c_OWN_LSU);
    o_lsu_err    = w_tmo    && (r_owner == c_OWN_LSU);
    o_lsu_rdata  = (w_fwd_rdata && r_owner == c_OWN_LSU) ? i_mem_rdata : '0;
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wmask = r_mem_wmask;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_mem_arbiter.sv
`default_nettype none
// Directed bench for ysyx_22050710_mem_arbiter (watchdog=4 instance plus a watchdog-off instance).
module tb_ysyx_22050710_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req = 1'b0;
  logic [63:0] ifu_addr = '0;
  logic        lsu_req = 1'b0, lsu_we = 1'b0;
  logic [63:0] lsu_addr = '0, lsu_wdata = '0;
  logic [7:0]  lsu_wmask = '0;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  logic        ifu_gnt, ifu_rvalid, ifu_err, lsu_gnt, lsu_rvalid, lsu_err, mem_req, mem_we;
  logic [63:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        n_ifu_gnt, n_ifu_rvalid, n_ifu_err, n_lsu_gnt, n_lsu_rvalid, n_lsu_err, n_mem_req, n_mem_we;
  logic [63:0] n_ifu_rdata, n_lsu_rdata, n_mem_addr, n_mem_wdata;
  logic [7:0]  n_mem_wmask;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_22050710_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ifu_req(ifu_req), .i_ifu_addr(ifu_addr),
    .o_ifu_gnt(ifu_gnt), .o_ifu_rvalid(ifu_rvalid), .o_ifu_rdata(ifu_rdata), .o_ifu_err(ifu_err),
    .i_lsu_req(lsu_req), .i_lsu_we(lsu_we), .i_lsu_addr(lsu_addr),
    .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
    .o_lsu_gnt(lsu_gnt), .o_lsu_rvalid(lsu_rvalid), .o_lsu_rdata(lsu_rdata), .o_lsu_err(lsu_err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  ysyx_22050710_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(0)) dut_nt (
    .i_clk(clk), .i_rst(rst),
    .i_ifu_req(ifu_req), .i_ifu_addr(ifu_addr),
    .o_ifu_gnt(n_ifu_gnt), .o_ifu_rvalid(n_ifu_rvalid), .o_ifu_rdata(n_ifu_rdata), .o_ifu_err(n_ifu_err),
    .i_lsu_req(lsu_req), .i_lsu_we(lsu_we), .i_lsu_addr(lsu_addr),
    .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
    .o_lsu_gnt(n_lsu_gnt), .o_lsu_rvalid(n_lsu_rvalid), .o_lsu_rdata(n_lsu_rdata), .o_lsu_err(n_lsu_err),
    .o_mem_req(n_mem_req), .o_mem_we(n_mem_we), .o_mem_addr(n_mem_addr),
    .o_mem_wdata(n_mem_wdata), .o_mem_wmask(n_mem_wmask),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
    checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if ({mem_we, mem_wmask, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_payload: got %0h want 0", {mem_we, mem_wmask, mem_wdata}); end
    checks++; if ({ifu_gnt, ifu_rvalid, ifu_err, lsu_gnt, lsu_rvalid, lsu_err} !== 6'b0) begin
      errors++; $display("FAIL reset_master_strobes: got %b want 000000", {ifu_gnt, ifu_rvalid, ifu_err, lsu_gnt, lsu_rvalid, lsu_err}); end
  endtask

  task automatic test_ifu_read;
    ifu_addr = 64'h8000_0000;
    ifu_req  = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ifu_idle_req: got %0h want 0", mem_req); end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ifu_mem_req: got %0h want 1", mem_req); end
    checks++; if (mem_addr !== 64'h8000_0000) begin errors++; $display("FAIL ifu_mem_addr: got %h want 80000000", mem_addr); end
    checks++; if ({mem_we, mem_wmask} !== 9'h0) begin errors++; $display("FAIL ifu_mem_we_mask: got %h want 0", {mem_we, mem_wmask}); end
    checks++; if ({ifu_gnt, lsu_gnt} !== 2'b10) begin errors++; $display("FAIL ifu_gnt: got %b want 10", {ifu_gnt, lsu_gnt}); end
    tick();
    ifu_req = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++; if ({ifu_gnt, mem_req, ifu_rvalid} !== 3'b000) begin errors++; $display("FAIL ifu_resp_wait: got %b want 000", {ifu_gnt, mem_req, ifu_rvalid}); end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_0013;
    #1;
    checks++; if ({ifu_rvalid, ifu_err} !== 2'b10) begin errors++; $display("FAIL ifu_rvalid_err: got %b want 10", {ifu_rvalid, ifu_err}); end
    checks++; if (ifu_rdata !== 64'h13) begin errors++; $display("FAIL ifu_rdata: got %h want 13", ifu_rdata); end
    checks++; if ({lsu_rvalid, lsu_gnt, lsu_rdata} !== '0) begin errors++; $display("FAIL ifu_lsu_quiet: got %h want 0", {lsu_rvalid, lsu_gnt, lsu_rdata}); end
    tick();
    mem_rvalid = 1'b0;
    #1;
    checks++; if ({ifu_rvalid, ifu_rdata} !== '0) begin errors++; $display("FAIL ifu_after_resp: got %h want 0", {ifu_rvalid, ifu_rdata}); end
  endtask

  task automatic test_lsu_write;
    lsu_req = 1'b1; lsu_we = 1'b1;
    lsu_addr = 64'h8000_0008; lsu_wdata = 64'hdead_beef; lsu_wmask = 8'h0f;
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if ({mem_we, mem_wmask} !== 9'h10f) begin errors++; $display("FAIL lsu_wr_we_mask: got %h want 10f", {mem_we, mem_wmask}); end
    checks++; if (mem_addr !== 64'h8000_0008) begin errors++; $display("FAIL lsu_wr_addr: got %h want 80000008", mem_addr); end
    checks++; if (mem_wdata !== 64'hdead_beef) begin errors++; $display("FAIL lsu_wr_wdata: got %h want deadbeef", mem_wdata); end
    checks++; if ({lsu_gnt, ifu_gnt} !== 2'b10) begin errors++; $display("FAIL lsu_wr_gnt: got %b want 10", {lsu_gnt, ifu_gnt}); end
    tick();
    lsu_req = 1'b0; lsu_we = 1'b0; mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hcafe;
    #1;
    checks++; if ({lsu_rvalid, lsu_err, ifu_rvalid} !== 3'b100) begin errors++; $display("FAIL lsu_wr_resp: got %b want 100", {lsu_rvalid, lsu_err, ifu_rvalid}); end
    checks++; if (lsu_rdata !== 64'h0) begin errors++; $display("FAIL lsu_wr_rdata: got %h want 0", lsu_rdata); end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_arbitration;
    logic [63:0] exp_addr [3];
    logic        exp_lsu  [3];
    int          gcyc     [3];
`ifdef YSYX_22050710_ARB_RR_EN
    exp_lsu[0] = 1'b1; exp_addr[0] = 64'h8000_2000;
    exp_lsu[1] = 1'b0; exp_addr[1] = 64'h8000_1000;
    exp_lsu[2] = 1'b1; exp_addr[2] = 64'h8000_3000;
`else
    exp_lsu[0] = 1'b1; exp_addr[0] = 64'h8000_2000;
    exp_lsu[1] = 1'b1; exp_addr[1] = 64'h8000_3000;
    exp_lsu[2] = 1'b0; exp_addr[2] = 64'h8000_1000;
`endif
    ifu_addr = 64'h8000_1000; lsu_addr = 64'h8000_2000; lsu_we = 1'b0;
    ifu_req = 1'b1; lsu_req = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick();
      mem_ready = 1'b1;
      #1;
      gcyc[r] = cyc;
      checks++; if ({lsu_gnt, ifu_gnt} !== {exp_lsu[r], ~exp_lsu[r]}) begin
        errors++; $display("FAIL arb_gnt_round%0d: got %b want %b", r, {lsu_gnt, ifu_gnt}, {exp_lsu[r], ~exp_lsu[r]}); end
      checks++; if ({mem_addr, mem_wmask} !== {exp_addr[r], 8'h00}) begin
        errors++; $display("FAIL arb_addr_round%0d: got %h want %h", r, {mem_addr, mem_wmask}, {exp_addr[r], 8'h00}); end
      tick();
      mem_ready = 1'b0;
      if (exp_lsu[r]) begin
        if (r == 0) lsu_addr = 64'h8000_3000;
        else lsu_req = 1'b0;
      end else begin
        ifu_req = 1'b0;
      end
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h100 + 64'(r);
      #1;
      checks++; if ({lsu_rvalid, ifu_rvalid} !== {exp_lsu[r], ~exp_lsu[r]}) begin
        errors++; $display("FAIL arb_rvalid_round%0d: got %b want %b", r, {lsu_rvalid, ifu_rvalid}, {exp_lsu[r], ~exp_lsu[r]}); end
      checks++; if ((exp_lsu[r] ? lsu_rdata : ifu_rdata) !== 64'h100 + 64'(r)) begin
        errors++; $display("FAIL arb_rdata_round%0d: got %h want %h", r, (exp_lsu[r] ? lsu_rdata : ifu_rdata), 64'h100 + 64'(r)); end
      tick();
      mem_rvalid = 1'b0;
    end
    checks++; if (gcyc[1] - gcyc[0] !== 4) begin errors++; $display("FAIL arb_gnt_spacing: got %0d want 4", gcyc[1] - gcyc[0]); end
  endtask

  task automatic test_timeout;
    ifu_addr = 64'h8000_4000; ifu_req = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rdata = 64'hbad;
    ifu_addr = 64'h8000_5000;
    #1;
    checks++; if (mem_addr !== 64'h8000_4000) begin errors++; $display("FAIL tmo_payload_latched: got %h want 80004000", mem_addr); end
    checks++; if (ifu_gnt !== 1'b0) begin errors++; $display("FAIL tmo_early_gnt0: got %0h want 0", ifu_gnt); end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++; if ({ifu_gnt, ifu_err} !== 2'b00) begin errors++; $display("FAIL tmo_early_gnt%0d: got %b want 00", i, {ifu_gnt, ifu_err}); end
    end
    tick();
    checks++; if ({ifu_gnt, ifu_rvalid, ifu_err} !== 3'b111) begin errors++; $display("FAIL tmo_req_abort: got %b want 111", {ifu_gnt, ifu_rvalid, ifu_err}); end
    checks++; if (ifu_rdata !== 64'h0) begin errors++; $display("FAIL tmo_req_rdata: got %h want 0", ifu_rdata); end
    checks++; if ({lsu_gnt, lsu_rvalid, lsu_err} !== 3'b000) begin errors++; $display("FAIL tmo_lsu_quiet: got %b want 000", {lsu_gnt, lsu_rvalid, lsu_err}); end
    tick();
    ifu_req = 1'b0; mem_ready = 1'b1;
    #1;
    checks++; if ({mem_req, ifu_gnt, ifu_rvalid} !== 3'b000) begin errors++; $display("FAIL tmo_idle_after: got %b want 000", {mem_req, ifu_gnt, ifu_rvalid}); end
    tick();
    mem_ready = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tmo_late_ready: got %0h want 0", mem_req); end
    // Response-phase abort on the LSU side.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_6000;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; lsu_req = 1'b0;
    #1;
    checks++; if (lsu_rvalid !== 1'b0) begin errors++; $display("FAIL tmo_resp_early: got %0h want 0", lsu_rvalid); end
    tick(); tick(); tick();
    checks++; if ({lsu_rvalid, lsu_err, lsu_gnt} !== 3'b110) begin errors++; $display("FAIL tmo_resp_abort: got %b want 110", {lsu_rvalid, lsu_err, lsu_gnt}); end
    checks++; if (lsu_rdata !== 64'h0) begin errors++; $display("FAIL tmo_resp_rdata: got %h want 0", lsu_rdata); end
    tick();
    mem_rdata = '0;
  endtask

  task automatic test_reset_in_resp;
    ifu_addr = 64'h8000_7000; ifu_req = 1'b1;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; ifu_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77;
    #1;
    checks++; if ({ifu_rvalid, lsu_rvalid, ifu_rdata} !== '0) begin errors++; $display("FAIL rst_resp_no_rvalid: got %h want 0", {ifu_rvalid, lsu_rvalid, ifu_rdata}); end
    checks++; if ({mem_req, mem_addr} !== '0) begin errors++; $display("FAIL rst_resp_mem_clear: got %h want 0", {mem_req, mem_addr}); end
    mem_rvalid = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_8000;
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if ({lsu_gnt, mem_addr} !== {1'b1, 64'h8000_8000}) begin errors++; $display("FAIL rst_new_gnt: got %h want 180008000", {lsu_gnt, mem_addr}); end
    tick();
    lsu_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h55;
    #1;
    checks++; if ({lsu_rvalid, lsu_rdata} !== {1'b1, 64'h55}) begin errors++; $display("FAIL rst_new_resp: got %h want 10000000000000055", {lsu_rvalid, lsu_rdata}); end
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_no_timeout;
    int bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifu_addr = 64'h8000_9000; ifu_req = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (n_ifu_gnt || n_ifu_rvalid || n_ifu_err) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL nt_req_stall: got %0d strobes want 0", bad); end
    mem_ready = 1'b1;
    #1;
    checks++; if ({n_ifu_gnt, n_mem_addr} !== {1'b1, 64'h8000_9000}) begin errors++; $display("FAIL nt_gnt: got %h want 180009000", {n_ifu_gnt, n_mem_addr}); end
    tick();
    ifu_req = 1'b0; mem_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (n_ifu_rvalid || n_ifu_err) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL nt_resp_stall: got %0d strobes want 0", bad); end
    mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678_9abc_def0;
    #1;
    checks++; if ({n_ifu_rvalid, n_ifu_err} !== 2'b10) begin errors++; $display("FAIL nt_resp: got %b want 10", {n_ifu_rvalid, n_ifu_err}); end
    checks++; if (n_ifu_rdata !== 64'h1234_5678_9abc_def0) begin errors++; $display("FAIL nt_rdata: got %h want 123456789abcdef0", n_ifu_rdata); end
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_arbitration();
    test_timeout();
    test_reset_in_resp();
    test_no_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
